lb_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one LB register bus slave port (the LB2REG_IF input side) among NUM_MST LB masters, e.g. the MCU AXI4-Lite bridge and a UART/JTAG debug master. It serialises write and read transactions, issues a one-cycle request pulse to the slave, and routes the acknowledge and read data back to the granted master. A timeout watchdog terminates transactions the slave never acknowledges, so a missing register decode cannot hang the MCU.

---
 rtl/lb_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_lb_bus_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_bus_arbiter.sv
// Round-robin arbiter sharing one LB register slave among NUM_MST masters, with a
// watchdog that force-completes transactions the slave never acknowledges.
module lb_bus_arbiter #(
  parameter int unsigned      NUM_MST      = 2,
  parameter int unsigned      ADR_W        = 32,
  parameter int unsigned      DAT_W        = 32,
  parameter int unsigned      TIMEOUT_CYC  = 256,
  parameter logic [DAT_W-1:0] TIMEOUT_RDAT = DAT_W'(32'hDEAD_BEEF),
  localparam int unsigned     IDX_W        = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_MST-1:0]       M_LB_WREQ,
  input  logic [NUM_MST*ADR_W-1:0] M_LB_WADR,
  input  logic [NUM_MST*DAT_W-1:0] M_LB_WDAT,
  output logic [NUM_MST-1:0]       M_LB_WACK,
  input  logic [NUM_MST-1:0]       M_LB_RREQ,
  input  logic [NUM_MST*ADR_W-1:0] M_LB_RADR,
  output logic [DAT_W-1:0]         M_LB_RDAT,
  output logic [NUM_MST-1:0]       M_LB_RACK,
  output logic                     S_LB_WREQ,
  output logic [ADR_W-1:0]         S_LB_WADR,
  output logic [DAT_W-1:0]         S_LB_WDAT,
  input  logic                     S_LB_WACK,
  output logic                     S_LB_RREQ,
  output logic [ADR_W-1:0]         S_LB_RADR,
  input  logic [DAT_W-1:0]         S_LB_RDAT,
  input  logic                     S_LB_RACK,
  output logic                     BUSY,
  output logic [IDX_W-1:0]         GNT_IDX,
  output logic                     ERR_TIMEOUT,
  output logic [15:0]              ERR_CNT
);

  localparam int unsigned    TMR_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit             TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               is_rd_q, is_rd_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   wdat_q, wdat_d;
  logic [DAT_W-1:0]   rdat_q, rdat_d;
  logic               to_q, to_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [15:0]        err_cnt_q, err_cnt_d;

  logic [NUM_MST-1:0] pending;
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   cand;
  logic               ack_hit;

  // Scan upward from the master after the last grant, wrapping once around.
  always_comb begin
    pending   = M_LB_WREQ | M_LB_RREQ;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(NUM_MST); k++) begin
      cand = IDX_W'((int'(last_q) + k) % int'(NUM_MST));
      if (!arb_found && pending[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign ack_hit = is_rd_q ? S_LB_RACK : S_LB_WACK;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    is_rd_d   = is_rd_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    to_d      = to_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          gnt_d   = arb_idx;
          // Writes win when a master raises both request types together.
          is_rd_d = !M_LB_WREQ[arb_idx];
          adr_d   = is_rd_d ? M_LB_RADR[int'(arb_idx)*ADR_W +: ADR_W]
                            : M_LB_WADR[int'(arb_idx)*ADR_W +: ADR_W];
          wdat_d  = is_rd_d ? '0 : M_LB_WDAT[int'(arb_idx)*DAT_W +: DAT_W];
          rdat_d  = '0;
          to_d    = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue, StWait: begin
        timer_d = (state_q == StIssue) ? '0 : timer_q + 1'b1;
        if (ack_hit) begin
          rdat_d  = is_rd_q ? S_LB_RDAT : '0;
          state_d = StResp;
        end else if (TO_EN && state_q == StWait && timer_q == TO_LAST) begin
          rdat_d  = is_rd_q ? TIMEOUT_RDAT : '0;
          to_d    = 1'b1;
          state_d = StResp;
        end else if (state_q == StIssue) begin
          state_d = StWait;
        end
      end
      StResp: begin
        last_d = gnt_q;
        if (to_q && err_cnt_q != 16'hFFFF) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      last_q    <= IDX_W'(NUM_MST - 1);
      gnt_q     <= '0;
      is_rd_q   <= 1'b0;
      adr_q     <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      to_q      <= 1'b0;
      timer_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      is_rd_q   <= is_rd_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      to_q      <= to_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    M_LB_WACK   = '0;
    M_LB_RACK   = '0;
    M_LB_RDAT   = '0;
    S_LB_WREQ   = 1'b0;
    S_LB_RREQ   = 1'b0;
    S_LB_WADR   = '0;
    S_LB_WDAT   = '0;
    S_LB_RADR   = '0;
    BUSY        = (state_q != StIdle);
    GNT_IDX     = gnt_q;
    ERR_TIMEOUT = 1'b0;
    ERR_CNT     = err_cnt_q;
    // Slave address/data stay stable from the request pulse through the master ack.
    if (state_q != StIdle) begin
      if (is_rd_q) begin
        S_LB_RADR = adr_q;
      end else begin
        S_LB_WADR = adr_q;
        S_LB_WDAT = wdat_q;
      end
    end
    if (state_q == StIssue) begin
      S_LB_WREQ = !is_rd_q;
      S_LB_RREQ = is_rd_q;
    end
    if (state_q == StResp) begin
      if (is_rd_q) begin
        M_LB_RACK[gnt_q] = 1'b1;
      end else begin
        M_LB_WACK[gnt_q] = 1'b1;
      end
      M_LB_RDAT   = rdat_q;
      ERR_TIMEOUT = to_q;
    end
  end

endmodule

// File: tb/tb_lb_bus_arbiter.sv
// Bench for lb_bus_arbiter: scripted scenarios plus randomized traffic checked against a
// round-robin transaction model with a scripted-latency slave.
module tb_lb_bus_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [NM-1:0] M_LB_WREQ = '0, M_LB_RREQ = '0, M_LB_WACK, M_LB_RACK;
  logic [NM*AW-1:0] M_LB_WADR = '0, M_LB_RADR = '0;
  logic [NM*DW-1:0] M_LB_WDAT = '0;
  logic [DW-1:0] M_LB_RDAT;
  logic          S_LB_WREQ, S_LB_RREQ;
  logic [AW-1:0] S_LB_WADR, S_LB_RADR;
  logic [DW-1:0] S_LB_WDAT;
  logic          S_LB_WACK = 1'b0, S_LB_RACK = 1'b0;
  logic [DW-1:0] S_LB_RDAT = '0;
  logic          BUSY, ERR_TIMEOUT;
  logic [1:0]    GNT_IDX;
  logic [15:0]   ERR_CNT;

  lb_bus_arbiter #(.NUM_MST(NM), .ADR_W(AW), .DAT_W(DW), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST),
    .M_LB_WREQ(M_LB_WREQ), .M_LB_WADR(M_LB_WADR), .M_LB_WDAT(M_LB_WDAT), .M_LB_WACK(M_LB_WACK),
    .M_LB_RREQ(M_LB_RREQ), .M_LB_RADR(M_LB_RADR), .M_LB_RDAT(M_LB_RDAT), .M_LB_RACK(M_LB_RACK),
    .S_LB_WREQ(S_LB_WREQ), .S_LB_WADR(S_LB_WADR), .S_LB_WDAT(S_LB_WDAT), .S_LB_WACK(S_LB_WACK),
    .S_LB_RREQ(S_LB_RREQ), .S_LB_RADR(S_LB_RADR), .S_LB_RDAT(S_LB_RDAT), .S_LB_RACK(S_LB_RACK),
    .BUSY(BUSY), .GNT_IDX(GNT_IDX), .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cyc; bit rd; int idx; logic [31:0] adr; logic [31:0] dat; int dly;
    logic [NM-1:0] pw; logic [NM-1:0] pr;
  } iss_t;
  typedef struct { int cyc; bit rd; int idx; logic [31:0] dat; bit to; } ack_t;
  typedef struct { int idx; bit rd; logic [31:0] adr; logic [31:0] dat; } exp_t;

  iss_t iss_q[$];
  ack_t ack_q[$];
  int   cyc = 0;
  int   to_pulses = 0;
  int   multi_err = 0;
  int   slv_dly = 0;          // -1: never ack, -2: random per transaction
  bit   slv_fix = 1'b0;
  logic [31:0] slv_rdat = '0;
  int   total = 0;
  int   bad = 0;

  function automatic logic [31:0] hrd(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_F0F0;
  endfunction

  function automatic int rr_pick(input int last, input logic [NM-1:0] pend);
    for (int k = 1; k <= NM; k++) begin
      if (pend[(last + k) % NM]) return (last + k) % NM;
    end
    return -1;
  endfunction

  // Slave responder and bus logger, all on the falling edge.
  initial begin
    logic [NM-1:0] prev_w, prev_r;
    bit armed, pend_rd;
    int cnt, d;
    logic [31:0] pend_adr;
    iss_t e;
    ack_t a;
    prev_w = '0; prev_r = '0; armed = 0; pend_rd = 0; cnt = 0; pend_adr = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      S_LB_WACK = 1'b0; S_LB_RACK = 1'b0; S_LB_RDAT = '0;
      if (RST) begin
        armed = 0;
      end else begin
        if (S_LB_WREQ || S_LB_RREQ) begin
          if (S_LB_WREQ && S_LB_RREQ) multi_err++;
          d = (slv_dly == -2) ? (($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3)))
                              : slv_dly;
          e.cyc = cyc; e.rd = S_LB_RREQ; e.idx = int'(GNT_IDX);
          e.adr = S_LB_RREQ ? S_LB_RADR : S_LB_WADR; e.dat = S_LB_WDAT; e.dly = d;
          e.pw = prev_w; e.pr = prev_r;
          iss_q.push_back(e);
          armed = (d >= 0); cnt = d; pend_rd = S_LB_RREQ; pend_adr = e.adr;
        end
        if (armed) begin
          if (cnt == 0) begin
            armed = 0;
            if (pend_rd) begin
              S_LB_RACK = 1'b1;
              S_LB_RDAT = slv_fix ? slv_rdat : hrd(pend_adr);
            end else begin
              S_LB_WACK = 1'b1;
            end
          end else begin
            cnt--;
          end
        end
      end
      if ((M_LB_WACK | M_LB_RACK) != '0) begin
        if ($countones(M_LB_WACK | M_LB_RACK) != 1) multi_err++;
        a.cyc = cyc; a.rd = (M_LB_RACK != '0); a.dat = M_LB_RDAT; a.to = ERR_TIMEOUT; a.idx = -1;
        for (int i = 0; i < NM; i++) if (M_LB_WACK[i] || M_LB_RACK[i]) a.idx = i;
        ack_q.push_back(a);
      end
      if (ERR_TIMEOUT) to_pulses++;
      prev_w = M_LB_WREQ; prev_r = M_LB_RREQ;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // One clock step; masters drop a request as soon as its ack is visible.
  task automatic step();
    @(posedge CLK);
    #1;
    M_LB_WREQ = M_LB_WREQ & ~M_LB_WACK;
    M_LB_RREQ = M_LB_RREQ & ~M_LB_RACK;
  endtask

  task automatic wait_acks(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (ack_q.size() >= n) ok = 1;
      else step();
    end
    if (ack_q.size() >= n) ok = 1;
  endtask

  task automatic clear_logs();
    iss_q.delete();
    ack_q.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1; M_LB_WREQ = '0; M_LB_RREQ = '0;
    step(); step(); step();
    total++;
    if ({S_LB_WREQ, S_LB_RREQ, M_LB_WACK, M_LB_RACK, ERR_TIMEOUT, BUSY} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0",
               {S_LB_WREQ, S_LB_RREQ, M_LB_WACK, M_LB_RACK, ERR_TIMEOUT, BUSY});
    end
    total++;
    if ({S_LB_WADR, S_LB_WDAT, S_LB_RADR, M_LB_RDAT} !== '0) begin
      bad++; $display("FAIL reset_bus: got nonzero bus value, want 0");
    end
    total++;
    if (ERR_CNT !== 16'd0) begin bad++; $display("FAIL reset_errcnt: got %0d want 0", ERR_CNT); end
    RST = 1'b0;
    step();
    clear_logs();
  endtask

  task automatic test_single_write();
    bit ok;
    clear_logs(); slv_dly = 2;
    M_LB_WADR[0 +: AW] = 32'h10; M_LB_WDAT[0 +: DW] = 32'hA5A5_0001; M_LB_WREQ[0] = 1'b1;
    wait_acks(1, 40, ok);
    step(); step(); step();
    total++;
    if (!ok || iss_q.size() != 1 || ack_q.size() != 1) begin
      bad++; $display("FAIL wr_count: got iss=%0d ack=%0d want 1/1", iss_q.size(), ack_q.size());
    end else begin
      total++;
      if (iss_q[0].rd || iss_q[0].adr !== 32'h10 || iss_q[0].dat !== 32'hA5A5_0001) begin
        bad++; $display("FAIL wr_slave: got rd=%0b adr=%h dat=%h want 0/10/a5a50001",
                        iss_q[0].rd, iss_q[0].adr, iss_q[0].dat);
      end
      total++;
      if (ack_q[0].rd || ack_q[0].idx != 0 || ack_q[0].cyc != iss_q[0].cyc + 3) begin
        bad++; $display("FAIL wr_ack: got rd=%0b idx=%0d dcyc=%0d want 0/0/3",
                        ack_q[0].rd, ack_q[0].idx, ack_q[0].cyc - iss_q[0].cyc);
      end
    end
  endtask

  task automatic test_read_m1();
    bit ok;
    int req_cyc;
    clear_logs(); slv_dly = 0; slv_fix = 1'b1; slv_rdat = 32'h1234_5678;
    M_LB_RADR[1*AW +: AW] = 32'h20; M_LB_RREQ[1] = 1'b1;
    req_cyc = cyc + 1;
    wait_acks(1, 40, ok);
    step();
    slv_fix = 1'b0;
    total++;
    if (!ok || iss_q.size() != 1 || ack_q.size() != 1) begin
      bad++; $display("FAIL rd_count: got iss=%0d ack=%0d want 1/1", iss_q.size(), ack_q.size());
    end else begin
      total++;
      if (!iss_q[0].rd || iss_q[0].adr !== 32'h20 || iss_q[0].idx != 1) begin
        bad++; $display("FAIL rd_slave: got rd=%0b adr=%h idx=%0d want 1/20/1",
                        iss_q[0].rd, iss_q[0].adr, iss_q[0].idx);
      end
      total++;
      if (!ack_q[0].rd || ack_q[0].idx != 1 || ack_q[0].dat !== 32'h1234_5678) begin
        bad++; $display("FAIL rd_ack: got rd=%0b idx=%0d dat=%h want 1/1/12345678",
                        ack_q[0].rd, ack_q[0].idx, ack_q[0].dat);
      end
      total++;
      if (ack_q[0].cyc != req_cyc + 2) begin
        bad++; $display("FAIL rd_latency: got %0d want %0d", ack_q[0].cyc - req_cyc, 2);
      end
    end
  endtask

  task automatic test_alternate();
    int n_set[2];
    RST = 1'b1; M_LB_WREQ = '0; M_LB_RREQ = '0;
    step(); step(); RST = 1'b0;
    clear_logs(); slv_dly = 1;
    n_set[0] = 0; n_set[1] = 0;
    for (int c = 0; c < 400 && ack_q.size() < 8; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!M_LB_WREQ[i] && n_set[i] < 4) begin
          M_LB_WADR[i*AW +: AW] = 32'h100 * (i + 1) + 32'(n_set[i] * 4);
          M_LB_WDAT[i*DW +: DW] = 32'hD000_0000 | 32'(i << 8) | 32'(n_set[i]);
          M_LB_WREQ[i] = 1'b1;
          n_set[i]++;
        end
      end
      step();
    end
    step(); step();
    total++;
    if (iss_q.size() != 8 || ack_q.size() != 8) begin
      bad++; $display("FAIL alt_count: got iss=%0d ack=%0d want 8/8", iss_q.size(), ack_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (iss_q[k].idx != k % 2 || ack_q[k].idx != k % 2) begin
          bad++; $display("FAIL alt_grant[%0d]: got gnt=%0d ack=%0d want %0d",
                          k, iss_q[k].idx, ack_q[k].idx, k % 2);
        end
        total++;
        if (iss_q[k].adr !== 32'h100 * (k % 2 + 1) + 32'((k / 2) * 4) ||
            iss_q[k].dat !== (32'hD000_0000 | 32'((k % 2) << 8) | 32'(k / 2))) begin
          bad++; $display("FAIL alt_data[%0d]: got adr=%h dat=%h", k, iss_q[k].adr, iss_q[k].dat);
        end
      end
    end
  endtask

  task automatic test_wr_rd_same();
    bit ok;
    clear_logs(); slv_dly = 1;
    M_LB_WADR[0 +: AW] = 32'h30; M_LB_WDAT[0 +: DW] = 32'h0BAD_F00D; M_LB_RADR[0 +: AW] = 32'h34;
    M_LB_WREQ[0] = 1'b1; M_LB_RREQ[0] = 1'b1;
    wait_acks(2, 60, ok);
    step(); step();
    total++;
    if (!ok || iss_q.size() != 2 || ack_q.size() != 2) begin
      bad++; $display("FAIL wr_rd_count: got iss=%0d ack=%0d want 2/2", iss_q.size(), ack_q.size());
    end else begin
      total++;
      if (iss_q[0].rd || iss_q[0].adr !== 32'h30 || !iss_q[1].rd || iss_q[1].adr !== 32'h34) begin
        bad++; $display("FAIL wr_rd_order: got %0b:%h then %0b:%h want 0:30 then 1:34",
                        iss_q[0].rd, iss_q[0].adr, iss_q[1].rd, iss_q[1].adr);
      end
      total++;
      if (ack_q[0].rd || !ack_q[1].rd || ack_q[1].dat !== hrd(32'h34) ||
          iss_q[1].cyc <= ack_q[0].cyc) begin
        bad++; $display("FAIL wr_rd_ack: got rd0=%0b rd1=%0b dat=%h want 0/1/%h",
                        ack_q[0].rd, ack_q[1].rd, ack_q[1].dat, hrd(32'h34));
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs(); slv_dly = -1;
    M_LB_RADR[1*AW +: AW] = 32'h44; M_LB_RREQ[1] = 1'b1;
    wait_acks(1, 80, ok);
    total++;
    if (!ok || iss_q.size() != 1) begin
      bad++; $display("FAIL to_count: got ack=%0d iss=%0d want 1/1", ack_q.size(), iss_q.size());
    end else begin
      total++;
      if (ack_q[0].cyc != iss_q[0].cyc + 17 || ack_q[0].idx != 1 || !ack_q[0].rd) begin
        bad++; $display("FAIL to_latency: got dcyc=%0d idx=%0d want 17/1",
                        ack_q[0].cyc - iss_q[0].cyc, ack_q[0].idx);
      end
      total++;
      if (ack_q[0].dat !== 32'hDEAD_BEEF || !ack_q[0].to) begin
        bad++; $display("FAIL to_data: got dat=%h err=%0b want deadbeef/1", ack_q[0].dat, ack_q[0].to);
      end
    end
    total++;
    if (ERR_CNT !== 16'd1) begin bad++; $display("FAIL to_errcnt: got %0d want 1", ERR_CNT); end
    clear_logs(); slv_dly = 0;
    M_LB_WADR[0 +: AW] = 32'h50; M_LB_WDAT[0 +: DW] = 32'h5; M_LB_WREQ[0] = 1'b1;
    wait_acks(1, 40, ok);
    step();
    total++;
    if (!ok || iss_q.size() != 1 || ack_q[0].to || ack_q[0].cyc != iss_q[0].cyc + 1 ||
        ERR_CNT !== 16'd1) begin
      bad++; $display("FAIL to_recover: got ack=%0d errcnt=%0d want 1/1", ack_q.size(), ERR_CNT);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs(); slv_dly = -1;
    M_LB_WADR[1*AW +: AW] = 32'h60; M_LB_WDAT[1*DW +: DW] = 32'h66; M_LB_WREQ[1] = 1'b1;
    step(); step(); step(); step();
    total++;
    if (BUSY !== 1'b1) begin bad++; $display("FAIL rstmid_busy: got %b want 1", BUSY); end
    RST = 1'b1;
    M_LB_WADR[0 +: AW] = 32'h64; M_LB_WDAT[0 +: DW] = 32'h77; M_LB_WREQ[0] = 1'b1;
    step();
    total++;
    if ({BUSY, S_LB_WREQ, S_LB_RREQ, M_LB_WACK, M_LB_RACK, ERR_TIMEOUT} !== '0 ||
        {S_LB_WADR, S_LB_WDAT, S_LB_RADR, M_LB_RDAT} !== '0 || ERR_CNT !== 16'd0) begin
      bad++; $display("FAIL rstmid_outputs: got busy=%b errcnt=%0d want all 0", BUSY, ERR_CNT);
    end
    step();
    total++;
    if (ack_q.size() != 0) begin
      bad++; $display("FAIL rstmid_noack: got %0d acks want 0", ack_q.size());
    end
    RST = 1'b0; slv_dly = 0;
    clear_logs();
    wait_acks(2, 60, ok);
    total++;
    if (!ok || iss_q.size() < 2 || iss_q[0].idx != 0 || iss_q[1].idx != 1) begin
      bad++; $display("FAIL rstmid_grant: got %0d issues, first gnt=%0d want 2, 0",
                      iss_q.size(), (iss_q.size() > 0) ? iss_q[0].idx : -1);
    end
    step(); step();
  endtask

  task automatic test_random();
    exp_t ex[$];
    exp_t x;
    int issued, last, tos, to0, exp_idx, exp_cyc, j;
    bit tmo;
    logic [31:0] exp_dat;
    RST = 1'b1; M_LB_WREQ = '0; M_LB_RREQ = '0;
    step(); step(); RST = 1'b0;
    clear_logs(); to0 = to_pulses; slv_dly = -2; issued = 0;
    for (int c = 0; c < 4000 && (issued < 60 || ack_q.size() < issued); c++) begin
      for (int i = 0; i < NM; i++) begin
        if (issued < 60 && !M_LB_WREQ[i] && !M_LB_RREQ[i] && $urandom_range(0, 3) == 0) begin
          int kind;
          kind = $urandom_range(0, 2);
          if (kind != 1) begin
            x.idx = i; x.rd = 0; x.adr = $urandom; x.dat = $urandom;
            M_LB_WADR[i*AW +: AW] = x.adr; M_LB_WDAT[i*DW +: DW] = x.dat; M_LB_WREQ[i] = 1'b1;
            ex.push_back(x); issued++;
          end
          if (kind != 0) begin
            x.idx = i; x.rd = 1; x.adr = $urandom; x.dat = '0;
            M_LB_RADR[i*AW +: AW] = x.adr; M_LB_RREQ[i] = 1'b1;
            ex.push_back(x); issued++;
          end
        end
      end
      step();
    end
    step(); step();
    total++;
    if (ack_q.size() != issued || iss_q.size() != issued) begin
      bad++; $display("FAIL rnd_count: got iss=%0d ack=%0d want %0d",
                      iss_q.size(), ack_q.size(), issued);
    end
    last = NM - 1; tos = 0;
    for (int k = 0; k < iss_q.size() && k < ack_q.size(); k++) begin
      exp_idx = rr_pick(last, iss_q[k].pw | iss_q[k].pr);
      total++;
      if (iss_q[k].idx != exp_idx) begin
        bad++; $display("FAIL rnd_grant[%0d]: got %0d want %0d", k, iss_q[k].idx, exp_idx);
      end
      j = -1;
      for (int m = ex.size() - 1; m >= 0; m--) if (ex[m].idx == iss_q[k].idx) j = m;
      total++;
      if (j < 0) begin
        bad++; $display("FAIL rnd_txn[%0d]: got unrequested transaction for master %0d",
                        k, iss_q[k].idx);
      end else begin
        if (iss_q[k].rd != ex[j].rd || iss_q[k].adr !== ex[j].adr ||
            (!ex[j].rd && iss_q[k].dat !== ex[j].dat)) begin
          bad++; $display("FAIL rnd_txn[%0d]: got rd=%0b adr=%h dat=%h want rd=%0b adr=%h dat=%h",
                          k, iss_q[k].rd, iss_q[k].adr, iss_q[k].dat, ex[j].rd, ex[j].adr, ex[j].dat);
        end
        ex.delete(j);
      end
      tmo = (iss_q[k].dly < 0);
      exp_cyc = iss_q[k].cyc + (tmo ? TO + 1 : iss_q[k].dly + 1);
      exp_dat = !iss_q[k].rd ? 32'h0 : (tmo ? 32'hDEAD_BEEF : hrd(iss_q[k].adr));
      total++;
      if (ack_q[k].cyc != exp_cyc || ack_q[k].idx != iss_q[k].idx || ack_q[k].rd != iss_q[k].rd ||
          ack_q[k].dat !== exp_dat || ack_q[k].to != tmo) begin
        bad++; $display("FAIL rnd_ack[%0d]: got cyc=%0d idx=%0d dat=%h to=%0b want %0d/%0d/%h/%0b",
                        k, ack_q[k].cyc, ack_q[k].idx, ack_q[k].dat, ack_q[k].to,
                        exp_cyc, iss_q[k].idx, exp_dat, tmo);
      end
      if (tmo) tos++;
      last = iss_q[k].idx;
    end
    total++;
    if (ex.size() != 0) begin bad++; $display("FAIL rnd_lost: got %0d unserved want 0", ex.size()); end
    total++;
    if (ERR_CNT !== 16'(tos) || to_pulses - to0 != tos) begin
      bad++; $display("FAIL rnd_errcnt: got cnt=%0d pulses=%0d want %0d",
                      ERR_CNT, to_pulses - to0, tos);
    end
    total++;
    if (multi_err != 0) begin
      bad++; $display("FAIL bus_onehot: got %0d bad cycles want 0", multi_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_m1();
    test_alternate();
    test_wr_rd_same();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
